// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit owning HI/LO: pipelined multiplier, radix-2^DIV_BITS divider.
// Define MDU_ACC_EN to accept MADD/MADDU/MSUB/MSUBU (HI/LO accumulate).
module mdu_seq #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DIV_BITS = 1,
    parameter int unsigned MUL_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        alucontrol_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              valid_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [DATA_W-1:0] mul_result_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [7:0] MTHI_CONTROL  = 8'h11;
    localparam logic [7:0] MTLO_CONTROL  = 8'h13;
    localparam logic [7:0] MULT_CONTROL  = 8'h18;
    localparam logic [7:0] MULTU_CONTROL = 8'h19;
    localparam logic [7:0] DIV_CONTROL   = 8'h1A;
    localparam logic [7:0] DIVU_CONTROL  = 8'h1B;
    localparam logic [7:0] MUL_CONTROL   = 8'h1C;
    localparam logic [7:0] MADD_CONTROL  = 8'h20;
    localparam logic [7:0] MADDU_CONTROL = 8'h21;
    localparam logic [7:0] MSUB_CONTROL  = 8'h24;
    localparam logic [7:0] MSUBU_CONTROL = 8'h25;

`ifdef MDU_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    localparam int unsigned DIV_ITERS = DATA_W / DIV_BITS;
    localparam int unsigned CNT_W     = $clog2(DIV_ITERS + MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [7:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q, hi_q, lo_q, mul_res_q;
    logic [DATA_W-1:0]   rem_q, quo_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] prod_q [MUL_LAT];

    logic                req_mul, req_div, req_mt, accept, last, commit;
    logic                sgn, a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a, mag_b, rem_nx, quo_nx, q_fix, r_fix;
    logic [DATA_W:0]     trial;
    logic [2*DATA_W-1:0] a_wide, b_wide, mul_commit;

    always_comb begin
        req_mul = 1'b0;
        req_div = 1'b0;
        req_mt  = 1'b0;
        case (alucontrol_i)
            MULT_CONTROL, MULTU_CONTROL, MUL_CONTROL: req_mul = 1'b1;
            MADD_CONTROL, MADDU_CONTROL,
            MSUB_CONTROL, MSUBU_CONTROL:              req_mul = ACC_EN;
            DIV_CONTROL, DIVU_CONTROL:                req_div = 1'b1;
            MTHI_CONTROL, MTLO_CONTROL:               req_mt  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        accept = ready_o && valid_i && !flush_i && (req_mul || req_div || req_mt);
        last   = ((state_q == MUL_RUN) && (cnt_q == CNT_W'(MUL_LAT))) ||
                 ((state_q == DIV_RUN) && (cnt_q == CNT_W'(DIV_ITERS)));
        commit = last && !flush_i;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // MTHI/MTLO ride through MUL_RUN with the counter preset so they commit one edge after acceptance.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) state_d = req_div ? DIV_RUN : MUL_RUN;
                    else        state_d = IDLE;
                end
                MUL_RUN, DIV_RUN: if (last) state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == IDLE) || (state_q == DONE);
        done_o  = (state_q == DONE);
    end

    always_comb begin
        case (op_q)
            MULT_CONTROL, MUL_CONTROL, DIV_CONTROL,
            MADD_CONTROL, MSUB_CONTROL: sgn = 1'b1;
            default:                    sgn = 1'b0;
        endcase
        a_neg  = sgn && a_q[DATA_W-1];
        b_neg  = sgn && b_q[DATA_W-1];
        mag_a  = a_neg ? -a_q : a_q;
        mag_b  = b_neg ? -b_q : b_q;
        a_wide = {{DATA_W{a_neg}}, a_q};
        b_wide = {{DATA_W{b_neg}}, b_q};
    end

    always_ff @(posedge clk) begin
        prod_q[0] <= a_wide * b_wide;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    always_comb begin
        mul_commit = prod_q[MUL_LAT-1];
`ifdef MDU_ACC_EN
        case (op_q)
            MADD_CONTROL, MADDU_CONTROL: mul_commit = {hi_q, lo_q} + prod_q[MUL_LAT-1];
            MSUB_CONTROL, MSUBU_CONTROL: mul_commit = {hi_q, lo_q} - prod_q[MUL_LAT-1];
            default: ;
        endcase
`endif
    end

    // Restoring division on magnitudes, DIV_BITS quotient bits per cycle; the first cycle seeds from the operands.
    always_comb begin
        rem_nx = (cnt_q == '0) ? '0    : rem_q;
        quo_nx = (cnt_q == '0) ? mag_a : quo_q;
        trial  = '0;
        for (int unsigned i = 0; i < DIV_BITS; i++) begin
            trial = {rem_nx, quo_nx[DATA_W-1]} - {1'b0, mag_b};
            if (!trial[DATA_W]) rem_nx = trial[DATA_W-1:0];
            else                rem_nx = {rem_nx[DATA_W-2:0], quo_nx[DATA_W-1]};
            quo_nx = {quo_nx[DATA_W-2:0], !trial[DATA_W]};
        end
        q_fix = (a_neg ^ b_neg) ? -quo_q : quo_q;
        r_fix = a_neg ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_res_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                op_q  <= alucontrol_i;
                a_q   <= a_i;
                b_q   <= b_i;
                cnt_q <= req_mt ? CNT_W'(MUL_LAT) : '0;
            end else if ((state_q == MUL_RUN) || (state_q == DIV_RUN)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((state_q == DIV_RUN) && !last) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
            end
            if (commit) begin
                case (op_q)
                    MTHI_CONTROL: hi_q <= a_q;
                    MTLO_CONTROL: lo_q <= a_q;
                    MUL_CONTROL:  mul_res_q <= mul_commit[DATA_W-1:0];
                    DIV_CONTROL, DIVU_CONTROL: begin
                        if (b_q == '0) begin
                            lo_q <= '1;
                            hi_q <= a_q;
                        end else begin
                            lo_q <= q_fix;
                            hi_q <= r_fix;
                        end
                    end
                    default: {hi_q, lo_q} <= mul_commit;
                endcase
            end
        end
    end

    always_comb begin
        hi_o         = hi_q;
        lo_o         = lo_q;
        mul_result_o = mul_res_q;
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table plus flush, back-to-back, radix-16 and reset sequences.
module tb_mdu_seq;

    localparam logic [7:0] MTHI  = 8'h11;
    localparam logic [7:0] MTLO  = 8'h13;
    localparam logic [7:0] MULT  = 8'h18;
    localparam logic [7:0] MULTU = 8'h19;
    localparam logic [7:0] DIV   = 8'h1A;
    localparam logic [7:0] DIVU  = 8'h1B;
    localparam logic [7:0] MUL   = 8'h1C;
    localparam logic [7:0] MADDU = 8'h21;
    localparam logic [7:0] MSUB  = 8'h24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  code = '0;
    logic [31:0] a_in = '0, b_in = '0;
    logic        valid = 1'b0, valid4 = 1'b0, flush = 1'b0;
    logic        ready_o, done_o, ready4, done4;
    logic [31:0] mres, hi, lo, mres4, hi4, lo4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_seq #(.DATA_W(32), .DIV_BITS(1), .MUL_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .alucontrol_i(code), .a_i(a_in), .b_i(b_in),
        .valid_i(valid), .flush_i(flush), .ready_o(ready_o), .done_o(done_o),
        .mul_result_o(mres), .hi_o(hi), .lo_o(lo)
    );

    mdu_seq #(.DATA_W(32), .DIV_BITS(4), .MUL_LAT(1)) u_dut4 (
        .clk(clk), .rst(rst), .alucontrol_i(code), .a_i(a_in), .b_i(b_in),
        .valid_i(valid4), .flush_i(flush), .ready_o(ready4), .done_o(done4),
        .mul_result_o(mres4), .hi_o(hi4), .lo_o(lo4)
    );

    typedef struct {
        logic [7:0]  code;
        logic [31:0] a, b, hi, lo, mres;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b, input bit to4);
        @(negedge clk);
        code = c;
        a_in = a;
        b_in = b;
        if (to4) valid4 = 1'b1;
        else     valid  = 1'b1;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        valid4 = 1'b0;
    endtask

    task automatic wait_done(input bit to4, output int n, output bit rdy_seen);
        n        = -1;
        rdy_seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if ((to4 ? done4 : done_o) === 1'b1) begin
                n = i;
                break;
            end
            if ((to4 ? ready4 : ready_o) === 1'b1) rdy_seen = 1'b1;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                          input bit to4, input int lat, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        bit rs;
        issue(c, a, b, to4);
        wait_done(to4, n, rs);
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_rdy_busy"}, 32'(rs), 32'd0);
        chk({name, "_hi"}, to4 ? hi4 : hi, ehi);
        chk({name, "_lo"}, to4 ? lo4 : lo, elo);
    endtask

    initial begin
        int  n;
        bit  rs;
        bit  seen;
        vecs[0]  = '{MTHI,  32'h11111111, 32'h0,        32'h11111111, 32'h00000000, 32'h0, 1};
        vecs[1]  = '{MTLO,  32'h22222222, 32'h0,        32'h11111111, 32'h22222222, 32'h0, 1};
        vecs[2]  = '{MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 3};
        vecs[3]  = '{MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 32'h0, 3};
        vecs[4]  = '{DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 33};
        vecs[5]  = '{DIVU,  32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 32'h0, 33};
        vecs[6]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h0, 33};
        vecs[7]  = '{DIVU,  32'h00000064, 32'h7,        32'h00000002, 32'h0000000E, 32'h0, 33};
        vecs[8]  = '{DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 32'h0, 33};
        vecs[9]  = '{MUL,   32'h00000003, 32'h5,        32'h00000002, 32'hFFFFFFF2, 32'hF, 3};
        vecs[10] = '{MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32'h0, 3};
        vecs[11] = '{DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'h0, 33};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_done",  32'(done_o),  32'd0);
        chk("rst_hi",    hi,   32'h0);
        chk("rst_lo",    lo,   32'h0);
        chk("rst_mres",  mres, 32'h0);
        chk("rst_ready4", 32'(ready4), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, 1'b0,
                   vecs[i].lat, vecs[i].hi, vecs[i].lo);
            if (vecs[i].code == MUL) chk($sformatf("v%0d_mres", i), mres, vecs[i].mres);
        end

        // Accumulate sequence
        run_op("mthi0", MTHI, 32'h0, 32'h0, 1'b0, 1, 32'h0, 32'hFFFFFFF9 + 32'h6);
        run_op("mtlo1", MTLO, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 32'h0, 32'hFFFFFFFF);
`ifdef MDU_ACC_EN
        run_op("maddu", MADDU, 32'h1, 32'h1, 1'b0, 3, 32'h1, 32'h0);
        run_op("msub",  MSUB,  32'h1, 32'h1, 1'b0, 3, 32'h0, 32'hFFFFFFFF);
`else
        issue(MADDU, 32'h1, 32'h1, 1'b0);
        chk("maddu_ready", 32'(ready_o), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1 || ready_o !== 1'b1) seen = 1'b1;
        end
        chk("maddu_ignored", 32'(seen), 32'd0);
        chk("maddu_hi", hi, 32'h0);
        chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

        // Flush mid-divide: flush sampled at edge 11
        issue(DIVU, 32'h64, 32'h7, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ready", 32'(ready_o), 32'd1);
        chk("flush_done",  32'(done_o),  32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        chk("flush_no_done", 32'(seen), 32'd0);
`ifdef MDU_ACC_EN
        chk("flush_hi", hi, 32'h0);
`else
        chk("flush_hi", hi, 32'h0);
`endif
        chk("flush_lo", lo, 32'hFFFFFFFF);
        run_op("post_flush", MULT, 32'h00010000, 32'h00010000, 1'b0, 3, 32'h1, 32'h0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done_o), 32'd0);

        // Back-to-back issue in the DONE cycle, operands changed after acceptance
        run_op("b2b_first", MULT, 32'h2, 32'h3, 1'b0, 3, 32'h0, 32'h6);
        chk("b2b_done_ready", 32'(ready_o && done_o), 32'd1);
        issue(MULTU, 32'h4, 32'h5, 1'b0);
        a_in = 32'hFFFFFFFF;
        b_in = 32'hFFFFFFFF;
        wait_done(1'b0, n, rs);
        chk("b2b_lat", 32'(n), 32'd3);
        chk("b2b_hi", hi, 32'h0);
        chk("b2b_lo", lo, 32'd20);

        // Radix-16 divider, single-stage multiplier
        run_op("r16_div",  DIV,  32'hFFFFFFF9, 32'h2,  1'b1, 9, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("r16_divu", DIVU, 32'hFFFFFFFF, 32'h10, 1'b1, 9, 32'h0000000F, 32'h0FFFFFFF);
        run_op("r16_mult", MULT, 32'hFFFFFFFF, 32'h2,  1'b1, 2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mul_only", MUL,  32'h3, 32'h5, 1'b0, 3, 32'h0, 32'd20);
        chk("mul_only_mres", mres, 32'd15);

        // Reset mid-operation clears HI/LO and returns to idle
        issue(DIV, 32'h64, 32'h7, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_hi",    hi, 32'h0);
        chk("midrst_lo",    lo, 32'h0);
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_done",  32'(done_o),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
